memwb_stage: RTL

MEM→WB pipeline register and write-back stage of the 5-stage CPU. Captures the MEM-stage result, aligns and extends load data returned by the synchronous data RAM, and drives the register file write port (`wa`/`wd`/`we`). Provides a stall-safe load-data holding buffer, misaligned-load detection and a retired-instruction counter.

---
 rtl/memwb_stage_pkg.sv | 32 +++
 rtl/memwb_stage_if.sv | 32 +++
 rtl/memwb_stage_load_align.sv | 55 +++++
 rtl/memwb_stage.sv | 79 +++++++
 4 files changed

// File: rtl/memwb_stage_pkg.sv
// Shared types and constants for the MEM->WB stage: load-type encoding,
// WB pipeline register layout and datapath widths.
package memwb_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int INSTRET_W  = 32;
  localparam int LD_TYPE_W  = 3;

  // Codes 6 and 7 are left unnamed and behave as LD_NONE.
  typedef enum logic [LD_TYPE_W-1:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LW   = 3'd5
  } ld_type_e;

  typedef struct packed {
    logic                  vld;
    logic [REG_ADDR_W-1:0] wa;
    logic                  wreg;
    logic [DATA_W-1:0]     wd;
    logic [LD_TYPE_W-1:0]  ld_type;
  } wb_reg_t;

  function automatic logic is_load(input logic [LD_TYPE_W-1:0] t);
    return (t >= LD_LB) && (t <= LD_LW);
  endfunction

endpackage

// File: rtl/memwb_stage_if.sv
// MEM-side inputs, data RAM read word, WB control and regfile write port
// bundled as one interface; the stage uses the slave modport.
interface memwb_stage_if;
  import memwb_stage_pkg::*;

  logic                  mem_valid;
  logic [REG_ADDR_W-1:0] mem_wa;
  logic                  mem_wreg;
  logic [DATA_W-1:0]     mem_wd;
  logic [LD_TYPE_W-1:0]  mem_ld_type;
  logic [DATA_W-1:0]     dm_rdata;
  logic                  wb_stall;
  logic                  wb_flush;
  logic [REG_ADDR_W-1:0] wb_wa;
  logic [DATA_W-1:0]     wb_wd;
  logic                  wb_we;
  logic                  wb_ade;
  logic [INSTRET_W-1:0]  instret;

  modport master (
    output mem_valid, mem_wa, mem_wreg, mem_wd, mem_ld_type,
    output dm_rdata, wb_stall, wb_flush,
    input  wb_wa, wb_wd, wb_we, wb_ade, instret
  );

  modport slave (
    input  mem_valid, mem_wa, mem_wreg, mem_wd, mem_ld_type,
    input  dm_rdata, wb_stall, wb_flush,
    output wb_wa, wb_wd, wb_we, wb_ade, instret
  );

endinterface

// File: rtl/memwb_stage_load_align.sv
// Combinational load alignment: picks the addressed byte/halfword out of a
// little-endian word, extends it, and flags misaligned halfword/word loads.
module load_align
  import memwb_stage_pkg::*;
(
  input  logic [DATA_W-1:0]    i_word,
  input  logic [1:0]           i_lo,
  input  logic [LD_TYPE_W-1:0] i_ld_type,
  output logic [DATA_W-1:0]    o_data,
  output logic                 o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  function automatic logic [DATA_W-1:0] ext8(input logic [7:0] b, input logic sgn);
    return sgn ? {{(DATA_W-8){b[7]}}, b} : {{(DATA_W-8){1'b0}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext16(input logic [15:0] h, input logic sgn);
    return sgn ? {{(DATA_W-16){h[15]}}, h} : {{(DATA_W-16){1'b0}}, h};
  endfunction

  always_comb begin
    w_byte = i_word[7:0];
    case (i_lo)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
  end

  assign w_half = i_lo[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data       = i_word;
    o_misaligned = 1'b0;
    case (i_ld_type)
      LD_LB:   o_data = ext8(w_byte, 1'b1);
      LD_LBU:  o_data = ext8(w_byte, 1'b0);
      LD_LH: begin
        o_data       = ext16(w_half, 1'b1);
        o_misaligned = i_lo[0];
      end
      LD_LHU: begin
        o_data       = ext16(w_half, 1'b0);
        o_misaligned = i_lo[0];
      end
      LD_LW:   o_misaligned = (i_lo != 2'b00);
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/memwb_stage.sv
// MEM->WB pipeline register and write-back: load-data holding buffer for
// stalls, misaligned-load detection and retired-instruction counter.
module memwb_stage
  import memwb_stage_pkg::*;
#(
  // Reset value of the retire counter; zero in normal use.
  parameter logic [INSTRET_W-1:0] INSTRET_RST = '0
)(
  input  logic          cpu_clk_50M,
  input  logic          cpu_rst_n,
  memwb_stage_if.slave  bus
);

  wb_reg_t              r_wb_p1;
  logic                 r_held_p1;
  logic [DATA_W-1:0]    r_ld_buf_p1;
  logic [INSTRET_W-1:0] r_instret;

  logic                 w_is_load;
  logic                 w_hold;
  logic                 w_retire;
  logic [DATA_W-1:0]    w_src;
  logic [DATA_W-1:0]    w_ld_data;
  logic                 w_mis;
  logic                 w_ade;

  assign w_is_load = is_load(r_wb_p1.ld_type);
  // The RAM word is only valid in the first WB cycle, so a stalled load snapshots it once.
  assign w_hold    = r_wb_p1.vld & w_is_load & bus.wb_stall & ~r_held_p1 & ~bus.wb_flush;
  assign w_retire  = r_wb_p1.vld & ~bus.wb_stall & ~bus.wb_flush;

  // MEM -> WB boundary
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_wb_p1     <= '0;
      r_held_p1   <= 1'b0;
      r_ld_buf_p1 <= '0;
    end else if (bus.wb_flush) begin
      r_wb_p1.vld <= 1'b0;
      r_held_p1   <= 1'b0;
    end else if (!bus.wb_stall) begin
      r_wb_p1     <= '{vld:     bus.mem_valid,
                       wa:      bus.mem_wa,
                       wreg:    bus.mem_wreg,
                       wd:      bus.mem_wd,
                       ld_type: bus.mem_ld_type};
      r_held_p1   <= 1'b0;
    end else if (w_hold) begin
      r_ld_buf_p1 <= bus.dm_rdata;
      r_held_p1   <= 1'b1;
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_instret <= INSTRET_RST;
    end else if (w_retire) begin
      r_instret <= r_instret + 1'b1;
    end
  end

  assign w_src = r_held_p1 ? r_ld_buf_p1 : bus.dm_rdata;

  load_align u_load_align (
    .i_word       (w_src),
    .i_lo         (r_wb_p1.wd[1:0]),
    .i_ld_type    (r_wb_p1.ld_type),
    .o_data       (w_ld_data),
    .o_misaligned (w_mis)
  );

  assign w_ade       = r_wb_p1.vld & w_is_load & w_mis;
  assign bus.wb_ade  = w_ade;
  assign bus.wb_wa   = r_wb_p1.wa;
  assign bus.wb_wd   = w_is_load ? w_ld_data : r_wb_p1.wd;
  assign bus.wb_we   = r_wb_p1.vld & r_wb_p1.wreg & (r_wb_p1.wa != '0) & ~w_ade;
  assign bus.instret = r_instret;

endmodule
